// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and config clamping helpers for the PE address generators
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wag_state_e;

  // A zero or oversized length means "use the whole buffer".
  function automatic int clamp_len(input int len, input int depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

  function automatic int clamp_base(input int base, input int depth);
    return (base >= depth) ? 0 : base;
  endfunction

endpackage

// File: rtl/wrap_add.sv
// rtl/wrap_add.sv - combinational (a + b) mod DEPTH for operands already below DEPTH
module wrap_add #(
  parameter int W     = 4,
  parameter int DEPTH = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] raw;

  // Both operands are below DEPTH, so one conditional subtract replaces a modulo.
  assign raw = {1'b0, a} + {1'b0, b};
  assign sum = (raw >= (W+1)'(DEPTH)) ? W'(raw - (W+1)'(DEPTH)) : raw[W-1:0];

endmodule

// File: rtl/write_addr_gen.sv
// rtl/write_addr_gen.sv - circular write address generator with wrap pulse, pass count and sticky done
module write_addr_gen
  import pe_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 12,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wrap,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done
);

  wag_state_e        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [PASS_W-1:0] passes_q;
  logic [ADDR_W-1:0] offset;

  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] base_eff;
  logic [ADDR_W-1:0] offset_inc;
  logic [ADDR_W-1:0] addr_inc;
  logic [PASS_W-1:0] pass_inc;
  logic              at_end;
  logic              last_pass;

  // len_q is one bit wider so a full 2^ADDR_W buffer length stays representable.
  assign len_eff    = (ADDR_W+1)'(clamp_len(int'(cfg_len), DEPTH));
  assign base_eff   = ADDR_W'(clamp_base(int'(cfg_base), DEPTH));
  assign offset_inc = offset + 1'b1;
  assign at_end     = ({1'b0, offset} == (len_q - 1'b1));
  assign pass_inc   = pass_cnt + 1'b1;
  assign last_pass  = (passes_q != '0) && (pass_inc == passes_q);

  wrap_add #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_wrap_add (
    .a   (base_q),
    .b   (offset_inc),
    .sum (addr_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= (ADDR_W+1)'(DEPTH);
      base_q   <= '0;
      passes_q <= '0;
      offset   <= '0;
      addr_out <= '0;
      wrap     <= 1'b0;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (init) begin
        state    <= RUN;
        len_q    <= len_eff;
        base_q   <= base_eff;
        passes_q <= cfg_passes;
        offset   <= '0;
        addr_out <= base_eff;
        pass_cnt <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else if (inc && (state == RUN)) begin
        if (at_end) begin
          offset   <= '0;
          addr_out <= base_q;
          wrap     <= 1'b1;
          pass_cnt <= pass_inc;
          if (last_pass) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          offset   <= offset_inc;
          addr_out <= addr_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_write_addr_gen.sv
// tb/tb_write_addr_gen.sv - scoreboard bench for write_addr_gen
module tb_write_addr_gen;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int PASS_W = 8;

  logic              clk;
  logic              rst;
  logic              init;
  logic [ADDR_W-1:0] cfg_len;
  logic [ADDR_W-1:0] cfg_base;
  logic [PASS_W-1:0] cfg_passes;
  logic              inc;
  logic [ADDR_W-1:0] addr_out;
  logic              wrap;
  logic [PASS_W-1:0] pass_cnt;
  logic              busy;
  logic              done;

  write_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PASS_W (PASS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .cfg_len    (cfg_len),
    .cfg_base   (cfg_base),
    .cfg_passes (cfg_passes),
    .inc        (inc),
    .addr_out   (addr_out),
    .wrap       (wrap),
    .pass_cnt   (pass_cnt),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int wrp;
    int pc;
    int bsy;
    int dne;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   wraps_seen = 0;

  // reference model state
  int m_state, m_off, m_len, m_base, m_passes, m_addr, m_wrap, m_pc, m_busy, m_done;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_off = 0; m_len = DEPTH; m_base = 0; m_passes = 0;
    m_addr = 0; m_wrap = 0; m_pc = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step(input bit i_init, input bit i_inc, input int len, input int base,
                            input int passes);
    m_wrap = 0;
    if (i_init) begin
      m_len    = (len == 0 || len > DEPTH) ? DEPTH : len;
      m_base   = (base >= DEPTH) ? 0 : base;
      m_passes = passes;
      m_off    = 0;
      m_addr   = m_base;
      m_pc     = 0;
      m_done   = 0;
      m_busy   = 1;
      m_state  = 1;
    end else if (i_inc && m_state == 1) begin
      if (m_off == m_len - 1) begin
        m_off  = 0;
        m_addr = m_base;
        m_wrap = 1;
        m_pc   = (m_pc + 1) % (1 << PASS_W);
        if (m_passes != 0 && m_pc == m_passes) begin
          m_state = 2;
          m_done  = 1;
          m_busy  = 0;
        end
      end else begin
        m_off  = m_off + 1;
        m_addr = (m_base + m_off) % DEPTH;
      end
    end
  endtask

  task automatic cycle(input bit i_init, input bit i_inc, input int len, input int base,
                       input int passes);
    exp_t e;
    @(negedge clk);
    init       = i_init;
    inc        = i_inc;
    cfg_len    = ADDR_W'(len);
    cfg_base   = ADDR_W'(base);
    cfg_passes = PASS_W'(passes);
    model_step(i_init, i_inc, len, base, passes);
    e = '{m_addr, m_wrap, m_pc, m_busy, m_done};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("addr", int'(addr_out), e.addr);
    chk("wrap", int'(wrap), e.wrp);
    chk("pass_cnt", int'(pass_cnt), e.pc);
    chk("busy", int'(busy), e.bsy);
    chk("done", int'(done), e.dne);
    wraps_seen += int'(wrap);
    init = 1'b0;
    inc  = 1'b0;
  endtask

  int exp_seq[9] = '{10, 11, 0, 1, 10, 11, 0, 1, 10};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init = 1'b0; inc = 1'b0;
    cfg_len = '0; cfg_base = '0; cfg_passes = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", int'(addr_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pc", int'(pass_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // full-depth single pass, then an ignored extra inc
    cycle(1, 0, 0, 0, 1);
    for (int k = 0; k < 12; k++) cycle(0, 1, 0, 0, 0);
    chk("t1_done", int'(done), 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_pc", int'(pass_cnt), 1);
    cycle(0, 1, 0, 0, 0);
    chk("t1_frozen_addr", int'(addr_out), 0);

    // wrapping window across the DEPTH boundary
    cycle(1, 0, 4, 10, 2);
    chk("t2_seq", int'(addr_out), exp_seq[0]);
    for (int k = 1; k < 9; k++) begin
      cycle(0, 1, 0, 0, 0);
      chk("t2_seq", int'(addr_out), exp_seq[k]);
      if (k == 4 || k == 8) chk("t2_wrap", int'(wrap), 1);
    end
    chk("t2_done", int'(done), 1);

    // unlimited passes
    cycle(1, 0, 3, 0, 0);
    wraps_seen = 0;
    for (int k = 0; k < 300; k++) cycle(0, 1, 0, 0, 0);
    chk("t3_wraps", wraps_seen, 100);
    chk("t3_pc", int'(pass_cnt), 100);
    chk("t3_done", int'(done), 0);

    // init wins over a simultaneous inc
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 0);
    chk("t4_pre_addr", int'(addr_out), 5);
    cycle(1, 1, 6, 2, 0);
    chk("t4_addr", int'(addr_out), 2);
    chk("t4_wrap", int'(wrap), 0);

    // asynchronous reset mid-run
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 0, 0);
    chk("t5_pre_addr", int'(addr_out), 7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_addr", int'(addr_out), 0);
    chk("t5_rst_busy", int'(busy), 0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
    chk("t5_idle_addr", int'(addr_out), 0);

    // oversized length and base clamp
    cycle(1, 0, 15, 13, 1);
    chk("b1_base", int'(addr_out), 0);
    for (int k = 0; k < 11; k++) cycle(0, 1, 0, 0, 0);
    chk("b1_addr11", int'(addr_out), 11);
    cycle(0, 1, 0, 0, 0);
    chk("b1_done", int'(done), 1);

    // len=1: every inc wraps
    cycle(1, 0, 1, 4, 3);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0);
      chk("b2_wrap", int'(wrap), 1);
      chk("b2_addr", int'(addr_out), 4);
    end
    chk("b2_done", int'(done), 1);
    chk("b2_pc", int'(pass_cnt), 3);
    cycle(0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
